// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the pipeline hazard logic and the iterative
// multiply/divide unit; the unit sits on the slave side.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] lvalue;
    logic [WIDTH-1:0] rvalue;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, lvalue, rvalue, flush, hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, lvalue, rvalue, flush, hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine producing one bit per cycle into the
// architectural HI/LO pair, with direct MTHI/MTLO writes while idle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset_n,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic signed [WIDTH-1:0] ZERO_S = '0;

    state_t               r_state, w_state_nx;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc, w_acc_nx, w_prod;
    logic [WIDTH-1:0]     r_opnd, r_hi, r_lo, w_res_hi, w_res_lo;
    logic [WIDTH-1:0]     w_lmag, w_rmag;
    logic [WIDTH:0]       w_sum, w_shift, w_trial;
    logic signed [WIDTH-1:0] w_lval_s, w_rval_s;
    logic r_is_div, r_neg, r_lneg, r_dz, r_div_zero;
    logic w_lneg, w_rneg, w_accept, w_launch, w_last, w_finish;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign w_lval_s = bus.lvalue;
    assign w_rval_s = bus.rvalue;
    assign w_lneg   = bus.op[0] && (w_lval_s < ZERO_S);
    assign w_rneg   = bus.op[0] && (w_rval_s < ZERO_S);
    assign w_lmag   = neg_if(bus.lvalue, w_lneg);
    assign w_rmag   = neg_if(bus.rvalue, w_rneg);

    assign w_accept = (r_state != S_RUN);
    assign w_launch = w_accept && bus.start && !bus.flush;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_finish = (r_state == S_RUN) && w_last && !bus.flush;

    // Shared accumulator: {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
        w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_opnd};
        if (!r_is_div)
            w_acc_nx = {w_sum, r_acc[WIDTH-1:1]};
        else if (!w_trial[WIDTH])
            w_acc_nx = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
            w_acc_nx = {r_acc[2*WIDTH-2:0], 1'b0};
    end

    // Sign fix-up on the final step; a zero divisor forces an all-ones quotient
    always_comb begin
        w_prod = r_neg ? -w_acc_nx : w_acc_nx;
        if (r_is_div) begin
            w_res_lo = r_dz ? '1 : neg_if(w_acc_nx[WIDTH-1:0], r_neg);
            w_res_hi = neg_if(w_acc_nx[2*WIDTH-1:WIDTH], r_lneg);
        end else begin
            w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (w_launch) begin
            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_lmag : w_rmag)};
            r_opnd   <= bus.op[1] ? w_rmag : w_lmag;
            r_is_div <= bus.op[1];
            r_neg    <= w_lneg ^ w_rneg;
            r_lneg   <= w_lneg;
            r_dz     <= bus.op[1] && (bus.rvalue == '0);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nx;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            if (w_launch)
                r_cnt <= '0;
            else if (r_state == S_RUN)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_finish) begin
                r_hi       <= w_res_hi;
                r_lo       <= w_res_lo;
                r_div_zero <= r_dz;
            end else if (w_accept && !bus.start) begin
                if (bus.hi_we) r_hi <= bus.wdata;
                if (bus.lo_we) r_lo <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN: begin
                if (bus.flush)   w_state_nx = S_IDLE;
                else if (w_last) w_state_nx = S_DONE;
            end
            default: w_state_nx = w_launch ? S_RUN : S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            S_RUN:   bus.busy = 1'b1;
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: transaction-level model of HI/LO/busy/done checked
// every cycle, plus literal expectations for the hand-worked cases.
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    int lat, nb;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference result as {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        logic signed [63:0] sa, sb, q, r;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'b00: return ua * ub;
            2'b01: return sa * sb;
            2'b10: return {(ua % ub), 32'b0} | {32'b0, (ua / ub)};
            default: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    int          m_left = 0;
    logic        m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] p_res = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_left != 0) begin
                if (bus.flush) begin
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_left <= 0;
                    m_hi   <= p_res[63:32];
                    m_lo   <= p_res[31:0];
                    m_done <= 1'b1;
                    m_dz   <= p_dz;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start && !bus.flush) begin
                m_left <= 32;
                p_res  <= ref_res(bus.op, bus.lvalue, bus.rvalue);
                p_dz   <= bus.op[1] && (bus.rvalue == 32'd0);
            end else if (!bus.start) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (bus.busy !== (m_left != 0) || bus.done !== m_done || bus.div_zero !== m_dz ||
            bus.hi !== m_hi || bus.lo !== m_lo) begin
            miscompares++;
            $display("FAIL cycle@%0t busy/done/dz/hi/lo: got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                     $time, bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo,
                     (m_left != 0), m_done, m_dz, m_hi, m_lo);
        end
    end

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the done cycle, or lat=-1 after 60 cycles
    task automatic wait_done(output int l, output int nbusy);
        l = -1;
        nbusy = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                l = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int l, output int nbusy);
        bus.start = 1'b1;
        bus.op = o;
        bus.lvalue = a;
        bus.rvalue = b;
        tick(1);
        bus.start = 1'b0;
        wait_done(l, nbusy);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start = 0; bus.op = 0; bus.lvalue = 0; bus.rvalue = 0;
        bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        lit("rst_busy", {31'b0, bus.busy}, 0);
        lit("rst_done", {31'b0, bus.done}, 0);
        lit("rst_hi", bus.hi, 0);
        lit("rst_lo", bus.lo, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        run_op(2'b00, 32'hFFFF_FFFF, 32'h2, lat, nb);
        lit("multu_lat", lat, 33);
        lit("multu_busy", nb, 32);
        lit("multu_hi", bus.hi, 32'h1);
        lit("multu_lo", bus.lo, 32'hFFFF_FFFE);
        run_op(2'b01, 32'hFFFF_FFFD, 32'h7, lat, nb);
        lit("mult_hi", bus.hi, 32'hFFFF_FFFF);
        lit("mult_lo", bus.lo, 32'hFFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'h2, lat, nb);
        lit("div_lo", bus.lo, 32'hFFFF_FFFD);
        lit("div_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd100, 32'd0, lat, nb);
        lit("dz_lo", bus.lo, 32'hFFFF_FFFF);
        lit("dz_hi", bus.hi, 32'h64);
        lit("dz_flag", {31'b0, bus.div_zero}, 1);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, nb);
        lit("ovf_lo", bus.lo, 32'h8000_0000);
        lit("ovf_hi", bus.hi, 32'h0);

        // Back-to-back: start held through DONE with the second operands
        bus.start = 1'b1; bus.op = 2'b10; bus.lvalue = 32'd17; bus.rvalue = 32'd5;
        tick(1);
        bus.lvalue = 32'd9; bus.rvalue = 32'd4;
        wait_done(lat, nb);
        lit("b2b1_lat", lat, 33);
        lit("b2b1_lo", bus.lo, 32'd3);
        lit("b2b1_hi", bus.hi, 32'd2);
        tick(1);
        bus.start = 1'b0;
        wait_done(lat, nb);
        lit("b2b2_lat", lat, 33);
        lit("b2b2_lo", bus.lo, 32'd2);
        lit("b2b2_hi", bus.hi, 32'd1);

        // Start pulse mid-RUN is ignored
        bus.start = 1'b1; bus.op = 2'b10; bus.lvalue = 32'd1000; bus.rvalue = 32'd7;
        tick(1);
        bus.start = 1'b0;
        tick(9);
        bus.start = 1'b1; bus.op = 2'b00; bus.lvalue = 32'd5; bus.rvalue = 32'd5;
        tick(1);
        bus.start = 1'b0;
        wait_done(lat, nb);
        lit("pulse_lat", lat, 23);
        lit("pulse_lo", bus.lo, 32'd142);
        lit("pulse_hi", bus.hi, 32'd6);
        wait_done(lat, nb);
        lit("pulse_nodone", lat, -1);

        // Flush in RUN leaves HI/LO untouched
        tick(1);
        bus.start = 1'b1; bus.op = 2'b00; bus.lvalue = 32'h1234; bus.rvalue = 32'h5678;
        tick(1);
        bus.start = 1'b0;
        tick(9);
        bus.flush = 1'b1;
        tick(1);
        bus.flush = 1'b0;
        wait_done(lat, nb);
        lit("flush_nodone", lat, -1);
        lit("flush_hi", bus.hi, 32'd6);
        lit("flush_lo", bus.lo, 32'd142);

        // Asynchronous reset mid-operation
        tick(1);
        bus.start = 1'b1; bus.op = 2'b01; bus.lvalue = 32'h1111; bus.rvalue = 32'hFFFF_FFFE;
        tick(1);
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        lit("arst_busy", {31'b0, bus.busy}, 0);
        lit("arst_hi", bus.hi, 0);
        tick(2);
        rst_n = 1'b1;
        wait_done(lat, nb);
        lit("arst_nodone", lat, -1);
        lit("arst_lo", bus.lo, 0);

        // MTHI / MTLO
        tick(1);
        bus.hi_we = 1'b1; bus.wdata = 32'hA5A5_A5A5;
        tick(1);
        bus.hi_we = 1'b0;
        lit("mthi", bus.hi, 32'hA5A5_A5A5);
        bus.lo_we = 1'b1; bus.wdata = 32'h5A5A_0F0F;
        tick(1);
        bus.lo_we = 1'b0;
        lit("mtlo", bus.lo, 32'h5A5A_0F0F);
        bus.start = 1'b1; bus.op = 2'b00; bus.lvalue = 32'd3; bus.rvalue = 32'd4;
        tick(1);
        bus.start = 1'b0;
        tick(5);
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick(1);
        bus.hi_we = 1'b0;
        wait_done(lat, nb);
        lit("run_wr_hi", bus.hi, 32'd0);
        lit("run_wr_lo", bus.lo, 32'd12);
        bus.hi_we = 1'b1; bus.wdata = 32'h1234_5678;
        bus.start = 1'b1; bus.op = 2'b00; bus.lvalue = 32'd5; bus.rvalue = 32'd6;
        tick(1);
        bus.start = 1'b0; bus.hi_we = 1'b0;
        lit("wr_start_hi", bus.hi, 32'd0);
        lit("wr_start_busy", {31'b0, bus.busy}, 1);
        wait_done(lat, nb);
        lit("wr_start_lo", bus.lo, 32'd30);

        // Randomized traffic checked cycle-by-cycle against the model
        for (int c = 0; c < 3000; c++) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.op     = 2'($urandom_range(0, 3));
            bus.lvalue = pick();
            bus.rvalue = pick();
            bus.flush  = ($urandom_range(0, 127) == 0);
            bus.hi_we  = ($urandom_range(0, 7) == 0);
            bus.lo_we  = ($urandom_range(0, 7) == 0);
            bus.wdata  = $urandom;
            tick(1);
        end
        bus.start = 0; bus.flush = 0; bus.hi_we = 0; bus.lo_we = 0;
        tick(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
